lcd_bus_driver: RTL and testbench
=================================

// Module: lcd_bus_driver
// PURPOSE
//  Far end of the LSU LCD I/O register path. Turns each 32-bit store to the LCD register into a timed
//  HD44780-style bus cycle on the LCD pins: setup, EN pulse, hold, then command execution wait.
//  Software no longer bit-bangs EN; it writes one word per command. Busy/overflow/read-back go to the LSU.
//  Holds a one-entry pending buffer, so one store can queue behind an active cycle.
// PARAMETERS
//  T_AS        2      cycles RS/RW/DATA stable before EN rises (>=1)
//  T_PW        12     cycles EN held high (>=1)
//  T_H         2      cycles EN low with bus held after EN falls (>=1)
//  T_EXEC      2000   cycles execution wait, normal command/data
//  T_EXEC_LONG 82000  cycles execution wait, clear/home (RS=0, data 8'h01 or 8'h02); counter width from this
// PORTS
//  i_clk          in   1   clock
//  i_reset        in   1   asynchronous reset, active-low
//  i_lcd_reg      in   32  command word: [31] ON, [9] RS, [8] RW, [7:0] DATA; other bits ignored
//  i_lcd_wr       in   1   one-cycle strobe: store to LCD register (LSU lcd decode & wren)
//  i_lcd_data_in  in   8   LCD data bus read-back
//  i_clr_ovf      in   1   clears o_overflow
//  o_lcd_on       out  1   LCD power/backlight, bit31 of last started command
//  o_lcd_rs       out  1   register select
//  o_lcd_rw       out  1   1 = read cycle
//  o_lcd_en       out  1   enable strobe
//  o_lcd_data     out  8   data bus drive value (tri-state ctrl outside, off when rw=1)
//  o_rd_data      out  8   last read-cycle sample
//  o_busy         out  1   state!=IDLE or pending valid
//  o_overflow     out  1   sticky: a store was dropped
// BEHAVIOUR
//  - Reset (async, i_reset=0): every output 0, state IDLE, pending empty, counter 0. Deassertion sync to i_clk.
//  - Reset mid-cycle: EN drops low immediately. The in-flight and pending commands are lost, with no partial retry.
//  - FSM: IDLE -> SETUP(T_AS) -> PULSE(T_PW) -> HOLD(T_H) -> WAIT(T_EXEC or T_EXEC_LONG) -> IDLE or SETUP.
//  - Each timed state lasts exactly its parameter count in cycles. The down-counter loads on entry; exit on count==1.
//  - Start: i_lcd_wr seen in IDLE with pending empty at edge k. SETUP at k+1.
//    At k+1: RS/RW/DATA/ON driven from the word, o_busy=1.
//  - EN high exactly cycles k+1+T_AS .. k+T_AS+T_PW. RS/RW/DATA stable from SETUP entry through HOLD end.
//  - Read cycle (RW=1): i_lcd_data_in sampled into o_rd_data on the last PULSE cycle (the edge EN falls).
//  - WAIT length picks T_EXEC_LONG iff RS=0 && RW=0 && DATA in {8'h01,8'h02}. Otherwise T_EXEC.
//  - WAIT end: pending valid -> SETUP with pending word, pending cleared. Otherwise IDLE.
//    o_busy drops the cycle IDLE is entered.
//  - i_lcd_wr while active and pending empty: word stored in pending, no bus effect.
//  - i_lcd_wr while pending full: word dropped, o_overflow=1 next cycle. Stays set until i_clr_ovf.
//  - Simultaneous events:
//    - i_clr_ovf with a drop in the same cycle: overflow stays set (set wins).
//    - i_lcd_wr on the WAIT-exit cycle with pending full: new word enters the freed slot. Not dropped.
//  - Outside active cycles EN=0. RS/RW/DATA hold the last values. ON changes only at SETUP entry.
// TESTING  (T_AS=1, T_PW=3, T_H=1, T_EXEC=5, T_EXEC_LONG=20)
//  1. Reset low mid-PULSE -> EN=0 in the same cycle, all outputs 0. o_busy=0 after release.
//  2. wr 32'h8000_0241 in IDLE at edge 0 -> RS=1, DATA=8'h41, ON=1 from cycle 1.
//     EN=1 cycles 2-4 only. IDLE (busy=0) at cycle 11.
//  3. wr 32'h0000_0001 (clear) -> WAIT is 20 cycles, busy=0 at cycle 26.
//     wr 32'h0000_0003 -> 5-cycle WAIT.
//  4. Read 32'h0000_0100, i_lcd_data_in=8'hA5 during PULSE -> o_rd_data=8'hA5 after EN falls.
//     o_rd_data unchanged by later writes.
//  5. Three strobes on cycles 0,1,2 -> cmd0 executes, cmd1 follows with no IDLE gap, cmd2 dropped.
//     o_overflow=1 from cycle 3. i_clr_ovf clears it.
//  6. Strobe on WAIT-exit cycle with pending full -> that word queued, no overflow.
//     Three back-to-back bus cycles observed.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// Purpose : turns each 32-bit store to the LCD register into one timed HD44780-style bus cycle.
// Latency : bus (RS/RW/DATA/ON) driven the cycle after the store; EN rises T_AS cycles later.
// Backpr. : no ready; one store queues behind the active cycle, further stores drop and set overflow.
//
// Ports:
//   i_clk, i_reset       clock, asynchronous active-low reset
//   i_lcd_reg, i_lcd_wr  command word ([31] ON, [9] RS, [8] RW, [7:0] DATA) and its store strobe
//   i_lcd_data_in        LCD data bus read-back, sampled as EN falls on read cycles
//   i_clr_ovf            clears the sticky overflow flag
//   o_lcd_*              LCD pins (EN strobe, RS, RW, DATA drive value, ON)
//   o_rd_data            last read-cycle sample
//   o_busy, o_overflow   status back to the LSU
module lcd_bus_driver #(
    parameter int T_AS        = 2,
    parameter int T_PW        = 12,
    parameter int T_H         = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    input  logic        i_lcd_wr,
    input  logic [7:0]  i_lcd_data_in,
    input  logic        i_clr_ovf,
    output logic        o_lcd_on,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic [7:0]  o_lcd_data,
    output logic [7:0]  o_rd_data,
    output logic        o_busy,
    output logic        o_overflow
);

    // The longest wait sets the counter width; every timed state shares one down-counter.
    localparam int CW = $clog2(T_EXEC_LONG + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;

    typedef struct packed {
        logic       on;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_cmd_t;

    function automatic lcd_cmd_t decode(input logic [31:0] w);
        lcd_cmd_t c;
        c.on   = w[31];
        c.rs   = w[9];
        c.rw   = w[8];
        c.data = w[7:0];
        return c;
    endfunction

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    lcd_cmd_t       cur;        // command currently on the bus (and held after it ends)
    lcd_cmd_t       pend;       // one-entry pending buffer
    logic           pend_vld;
    logic [7:0]     rd_data;
    logic           overflow;

    logic           load_new;   // start directly from the incoming store
    logic           load_pend;  // start from the pending buffer
    logic           pend_accept;
    logic           drop;
    logic           rd_sample;
    logic           cur_long;
    logic           last_cnt;

    // Bits 30:10 of the command word carry nothing for this block.
    logic           unused_reg_bits;
    assign unused_reg_bits = ^i_lcd_reg[30:10];

    // Clear display / return home need the long execution wait.
    assign cur_long = !cur.rs && !cur.rw && (cur.data == 8'h01 || cur.data == 8'h02);
    assign last_cnt = (cnt == CW'(1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state: each timed state loads its count on entry and leaves
    // when the count reaches 1, so it lasts exactly that many cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_new  = 1'b0;
        load_pend = 1'b0;
        unique case (state)
            IDLE: begin
                // A pending word can only sit here if it arrived on the
                // WAIT-exit cycle of a command that found the slot empty.
                if (pend_vld) begin
                    load_pend = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = CW'(T_AS);
                end else if (i_lcd_wr) begin
                    load_new  = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = CW'(T_AS);
                end
            end
            SETUP: begin
                if (last_cnt) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CW'(T_PW);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (last_cnt) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CW'(T_H);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (last_cnt) begin
                    state_nxt = WAIT;
                    cnt_nxt   = cur_long ? CW'(T_EXEC_LONG) : CW'(T_EXEC);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WAIT: begin
                if (last_cnt) begin
                    if (pend_vld) begin
                        // Chain straight into the next command, no IDLE gap.
                        load_pend = 1'b1;
                        state_nxt = SETUP;
                        cnt_nxt   = CW'(T_AS);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A store that does not start a cycle goes into the pending slot if the
    // slot is empty or is being emptied this very cycle; otherwise it drops.
    assign pend_accept = i_lcd_wr && !load_new && (!pend_vld || load_pend);
    assign drop        = i_lcd_wr && pend_vld && !load_pend;

    // Read data is captured on the edge that ends the pulse (EN falling).
    assign rd_sample   = (state == PULSE) && last_cnt && cur.rw;

    // ------------------------------------------------------------------
    // Datapath: bus word, pending buffer, read-back, overflow
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cur      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (load_new) begin
                cur <= decode(i_lcd_reg);
            end else if (load_pend) begin
                cur <= pend;
            end

            if (pend_accept) begin
                pend     <= decode(i_lcd_reg);
                pend_vld <= 1'b1;
            end else if (load_pend) begin
                pend_vld <= 1'b0;
            end

            if (rd_sample) begin
                rd_data <= i_lcd_data_in;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // EN decodes straight from the state register so an asynchronous reset
    // pulls it low without waiting for a clock edge.
    assign o_lcd_en   = (state == PULSE);
    assign o_lcd_on   = cur.on;
    assign o_lcd_rs   = cur.rs;
    assign o_lcd_rw   = cur.rw;
    assign o_lcd_data = cur.data;
    assign o_rd_data  = rd_data;
    assign o_busy     = (state != IDLE) || pend_vld;
    assign o_overflow = overflow;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Purpose : self-checking bench for lcd_bus_driver with short timing parameters.
// Latency : expected bus cycles are queued at issue time and matched when EN pulses complete.
// Backpr. : stores are issued as single-cycle strobes; no flow control on the bench side.
module tb_lcd_bus_driver;

    localparam int T_AS        = 1;
    localparam int T_PW        = 3;
    localparam int T_H         = 1;
    localparam int T_EXEC      = 5;
    localparam int T_EXEC_LONG = 20;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_lcd_reg;
    logic        i_lcd_wr;
    logic [7:0]  i_lcd_data_in;
    logic        i_clr_ovf;
    logic        o_lcd_on;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic [7:0]  o_lcd_data;
    logic [7:0]  o_rd_data;
    logic        o_busy;
    logic        o_overflow;

    lcd_bus_driver #(
        .T_AS       (T_AS),
        .T_PW       (T_PW),
        .T_H        (T_H),
        .T_EXEC     (T_EXEC),
        .T_EXEC_LONG(T_EXEC_LONG)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_lcd_reg    (i_lcd_reg),
        .i_lcd_wr     (i_lcd_wr),
        .i_lcd_data_in(i_lcd_data_in),
        .i_clr_ovf    (i_clr_ovf),
        .o_lcd_on     (o_lcd_on),
        .o_lcd_rs     (o_lcd_rs),
        .o_lcd_rw     (o_lcd_rw),
        .o_lcd_en     (o_lcd_en),
        .o_lcd_data   (o_lcd_data),
        .o_rd_data    (o_rd_data),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // cyc holds the number of the most recent rising edge.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       on;
        logic       rs;
        logic       rw;
        logic [7:0] data;
        int         start;   // cyc value of the first EN-high sample
        int         len;     // EN-high length in cycles
    } bus_t;

    bus_t exp_q[$];
    bus_t obs;
    bus_t exp_item;
    logic in_prog = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_bus(input logic on, input logic rs, input logic rw,
                              input logic [7:0] data, input int start);
        bus_t e;
        e.on    = on;
        e.rs    = rs;
        e.rw    = rw;
        e.data  = data;
        e.start = start;
        e.len   = T_PW;
        exp_q.push_back(e);
    endtask

    // Issue one store strobe; k is the edge number that samples it.
    task automatic strobe(input logic [31:0] w, output int k);
        k         = cyc + 1;
        i_lcd_reg = w;
        i_lcd_wr  = 1'b1;
        @(negedge i_clk);
        i_lcd_wr  = 1'b0;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) @(negedge i_clk);
    endtask

    // Monitor: one record per completed EN pulse, matched against the queue.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            in_prog = 1'b0;
        end else if (o_lcd_en && !in_prog) begin
            in_prog   = 1'b1;
            obs.on    = o_lcd_on;
            obs.rs    = o_lcd_rs;
            obs.rw    = o_lcd_rw;
            obs.data  = o_lcd_data;
            obs.start = cyc;
        end else if (!o_lcd_en && in_prog) begin
            in_prog = 1'b0;
            obs.len = cyc - obs.start;
            if (exp_q.size() == 0) begin
                check("bus_unexpected", 32'd1, 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                check("bus_word", {obs.on, obs.rs, obs.rw, obs.data},
                      {exp_item.on, exp_item.rs, exp_item.rw, exp_item.data});
                check("bus_en_start", obs.start, exp_item.start);
                check("bus_en_len", obs.len, exp_item.len);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int k0;
        i_reset       = 1'b0;
        i_lcd_reg     = '0;
        i_lcd_wr      = 1'b0;
        i_lcd_data_in = '0;
        i_clr_ovf     = 1'b0;

        repeat (2) @(negedge i_clk);
        check("reset_outputs", {o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data,
                                o_rd_data, o_busy, o_overflow}, 32'd0);
        i_reset = 1'b1;
        @(negedge i_clk);

        // 1: reset asserted mid-pulse
        strobe(32'h8000_0241, k);
        step_to(k + 2);
        check("t1_en_before_reset", o_lcd_en, 1'b1);
        #2 i_reset = 1'b0;
        #1;
        check("t1_en_drop", o_lcd_en, 1'b0);
        check("t1_all_zero", {o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data,
                              o_rd_data, o_busy, o_overflow}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("t1_busy_after_release", o_busy, 1'b0);
        check("t1_en_after_release", o_lcd_en, 1'b0);

        // 2: normal data write, ON=1 RS=1 DATA=41
        strobe(32'h8000_0241, k);
        expect_bus(1'b1, 1'b1, 1'b0, 8'h41, k + 1);
        check("t2_bus_at_setup", {o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_data}, {3'b110, 8'h41});
        check("t2_busy_at_setup", o_busy, 1'b1);
        check("t2_en_low_in_setup", o_lcd_en, 1'b0);
        step_to(k + 4);
        check("t2_en_low_in_hold", o_lcd_en, 1'b0);
        step_to(k + 9);
        check("t2_busy_last_wait", o_busy, 1'b1);
        step_to(k + 10);
        check("t2_idle", o_busy, 1'b0);
        check("t2_bus_held", {o_lcd_on, o_lcd_rs, o_lcd_data}, {2'b11, 8'h41});

        // 3: clear display takes the long wait, 0x03 the normal one
        strobe(32'h0000_0001, k);
        expect_bus(1'b0, 1'b0, 1'b0, 8'h01, k + 1);
        check("t3_on_off", o_lcd_on, 1'b0);
        step_to(k + 24);
        check("t3_long_busy_end", o_busy, 1'b1);
        step_to(k + 25);
        check("t3_long_idle", o_busy, 1'b0);
        strobe(32'h0000_0003, k);
        expect_bus(1'b0, 1'b0, 1'b0, 8'h03, k + 1);
        step_to(k + 9);
        check("t3_short_busy_end", o_busy, 1'b1);
        step_to(k + 10);
        check("t3_short_idle", o_busy, 1'b0);

        // 4: read cycle captures A5 as EN falls
        i_lcd_data_in = 8'hA5;
        strobe(32'h0000_0100, k);
        expect_bus(1'b0, 1'b0, 1'b1, 8'h00, k + 1);
        step_to(k + 3);
        check("t4_rd_before_fall", o_rd_data, 8'h00);
        step_to(k + 4);
        check("t4_rd_after_fall", o_rd_data, 8'hA5);
        i_lcd_data_in = 8'h5A;
        step_to(k + 10);
        check("t4_read_idle", o_busy, 1'b0);
        strobe(32'h0000_0241, k);
        expect_bus(1'b0, 1'b1, 1'b0, 8'h41, k + 1);
        step_to(k + 10);
        check("t4_rd_kept", o_rd_data, 8'hA5);

        // 5: three back-to-back strobes; third dropped
        strobe(32'h0000_0241, k0);
        expect_bus(1'b0, 1'b1, 1'b0, 8'h41, k0 + 1);
        strobe(32'h8000_0242, k);
        expect_bus(1'b1, 1'b1, 1'b0, 8'h42, k0 + 11);
        check("t5_ovf_before_drop", o_overflow, 1'b0);
        strobe(32'h0000_0243, k);
        check("t5_ovf_set", o_overflow, 1'b1);
        step_to(k0 + 9);
        check("t5_on_first_cmd", o_lcd_on, 1'b0);
        step_to(k0 + 10);
        check("t5_no_gap_busy", o_busy, 1'b1);
        check("t5_second_setup", {o_lcd_on, o_lcd_data}, {1'b1, 8'h42});
        step_to(k0 + 20);
        check("t5_idle", o_busy, 1'b0);
        check("t5_ovf_sticky", o_overflow, 1'b1);
        i_clr_ovf = 1'b1;
        @(negedge i_clk);
        i_clr_ovf = 1'b0;
        check("t5_ovf_cleared", o_overflow, 1'b0);

        // 6: strobe on the WAIT-exit cycle with pending full is queued
        strobe(32'h0000_0241, k0);
        expect_bus(1'b0, 1'b1, 1'b0, 8'h41, k0 + 1);
        strobe(32'h0000_0242, k);
        expect_bus(1'b0, 1'b1, 1'b0, 8'h42, k0 + 11);
        step_to(k0 + 9);
        strobe(32'h0000_0244, k);
        expect_bus(1'b0, 1'b1, 1'b0, 8'h44, k0 + 21);
        check("t6_exit_edge", k, k0 + 10);
        check("t6_no_ovf", o_overflow, 1'b0);
        step_to(k0 + 29);
        check("t6_busy_third", o_busy, 1'b1);
        step_to(k0 + 30);
        check("t6_idle", o_busy, 1'b0);
        check("t6_no_ovf_end", o_overflow, 1'b0);

        repeat (2) @(negedge i_clk);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
